// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, flag bit positions and FSM state encoding
//               for the multi-cycle ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    // Bit positions inside alu_flags
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative unsigned shift-add multiplier, one multiplier bit
//               per clock. 'done' flags the final iteration edge and 'product'
//               carries the accumulator value that edge will produce, so the
//               parent can register the finished product on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign busy       = r_busy;
    assign done       = r_busy & (r_cnt == c_last);
    assign product    = w_acc_next;

    // Load operands on start, then add/shift one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshake. Single-cycle ops
//               complete on the accept edge; MUL runs through the iterative
//               multiplier for WIDTH cycles. Result and NZCV are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       alu_flags
);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_accept;
    logic               w_is_mul;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic signed [WIDTH:0] w_asr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_flags;

    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [3:0]         w_mul_flags;

    assign in_ready   = rst_n & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign out_valid  = (r_state == ST_DONE);
    assign alu_result = r_result;
    assign alu_flags  = r_flags;

    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (alu_control == OP_MUL);
    assign w_amt    = src_b[SHW-1:0];

    // The extra top/bottom bit of each shift catches the last bit shifted out;
    // with amount 0 it stays 0, which gives carry = 0 for free.
    assign w_add = {1'b0, src_a} + {1'b0, src_b};
    assign w_sub = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
    assign w_shl = {1'b0, src_a} << w_amt;
    assign w_shr = {src_a, 1'b0} >> w_amt;
    assign w_asr = $signed({src_a, 1'b0}) >>> w_amt;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept & w_is_mul),
        .a       (src_a),
        .b       (src_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    assign w_mul_lo = w_mul_prod[WIDTH-1:0];

    // Single-cycle result, carry and overflow selected by opcode
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_control)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) & (w_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) & (w_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: w_res = src_a & src_b;
            OP_OR:  w_res = src_a | src_b;
            OP_XOR: w_res = src_a ^ src_b;
            OP_LSL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_LSR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_ASR: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    // Pack NZCV for both the single-cycle path and the multiplier path
    always_comb begin
        w_flags              = '0;
        w_flags[FLAG_N]      = w_res[WIDTH-1];
        w_flags[FLAG_Z]      = ~|w_res;
        w_flags[FLAG_C]      = w_c;
        w_flags[FLAG_V]      = w_v;
        w_mul_flags          = '0;
        w_mul_flags[FLAG_N]  = w_mul_lo[WIDTH-1];
        w_mul_flags[FLAG_Z]  = ~|w_mul_lo;
        w_mul_flags[FLAG_C]  = 1'b0;
        w_mul_flags[FLAG_V]  = |w_mul_prod[2*WIDTH-1:WIDTH];
    end

    // Control FSM and output registers; an accept in DONE retires the old
    // result and issues the new op on the same edge, exactly as from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state <= ST_MUL;
            end else begin
                r_state  <= ST_DONE;
                r_result <= w_res;
                r_flags  <= w_flags;
            end
        end else begin
            case (r_state)
                ST_MUL: begin
                    if (w_mul_busy && w_mul_done) begin
                        r_state  <= ST_DONE;
                        r_result <= w_mul_lo;
                        r_flags  <= w_mul_flags;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
